// File: rtl/conv_layer_pkg.sv
// Shared command/ack codes and controller state encoding for the conv layer input path.
// The input interface imports the same codes so both ends of the handshake agree.
package conv_layer_pkg;

  localparam logic [1:0] CMD_IDLE          = 2'd0;
  localparam logic [1:0] CMD_PRELOAD_START = 2'd1;
  localparam logic [1:0] CMD_SHIFT_START   = 2'd2;
  localparam logic [1:0] CMD_LOAD_START    = 2'd3;

  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_REQ,
    ST_PRE_WAIT,
    ST_SHIFT_REQ,
    ST_SHIFT_WAIT,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_DONE,
    ST_ERROR
  } ctrl_state_e;

  // Command driven while sitting in a REQ state; CMD_IDLE everywhere else.
  function automatic logic [1:0] req_cmd(input ctrl_state_e s);
    case (s)
      ST_PRE_REQ:   return CMD_PRELOAD_START;
      ST_SHIFT_REQ: return CMD_SHIFT_START;
      ST_LOAD_REQ:  return CMD_LOAD_START;
      default:      return CMD_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] expected_ack(input ctrl_state_e s);
    case (s)
      ST_PRE_WAIT:   return ACK_PRELOAD_FIN;
      ST_SHIFT_WAIT: return ACK_SHIFT_FIN;
      ST_LOAD_WAIT:  return ACK_LOAD_FIN;
      default:       return ACK_IDLE;
    endcase
  endfunction

  function automatic logic is_wait(input ctrl_state_e s);
    return (s == ST_PRE_WAIT) || (s == ST_SHIFT_WAIT) || (s == ST_LOAD_WAIT);
  endfunction

  function automatic logic is_req(input ctrl_state_e s);
    return (s == ST_PRE_REQ) || (s == ST_SHIFT_REQ) || (s == ST_LOAD_REQ);
  endfunction

endpackage

// File: rtl/conv_layer_ack_watchdog.sv
// Handshake watchdog: counts enabled cycles spent waiting for an ack.
// o_expired marks the enabled edge on which the count reaches TIMEOUT.
module conv_layer_ack_watchdog
  import conv_layer_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [TO_WIDTH-1:0] r_count;
  logic [TO_WIDTH-1:0] w_count_inc;
  logic                w_at_limit;

  assign w_count_inc = r_count + 1'b1;
  assign w_at_limit  = (r_count == TO_WIDTH'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (i_clear) begin
        r_count <= '0;
      end else if (i_run && !w_at_limit) begin
        r_count <= w_count_inc;
      end
    end
  end

  // Looking at the incremented value lets the FSM leave WAIT on the very edge
  // the count reaches TIMEOUT, so a WAIT lasts at most TIMEOUT enabled cycles.
  assign o_expired = i_run && (w_count_inc == TO_WIDTH'(TIMEOUT));

endmodule

// File: rtl/conv_layer_input_controller.sv
// Sequencer for one image pass over the conv layer input interface:
// PRELOAD once, then SHIFT/LOAD alternately until every output row has been shifted.
//
// state      | meaning
// IDLE       | waiting for start
// PRE_REQ    | cmd=PRELOAD_START for one enabled cycle
// PRE_WAIT   | waiting for PRELOAD_FIN
// SHIFT_REQ  | cmd=SHIFT_START for one enabled cycle
// SHIFT_WAIT | waiting for SHIFT_FIN, counts rows
// LOAD_REQ   | cmd=LOAD_START for one enabled cycle
// LOAD_WAIT  | waiting for LOAD_FIN
// DONE       | one-cycle done pulse
// ERROR      | handshake timed out; held until start or reset
module conv_layer_input_controller
  import conv_layer_pkg::*;
#(
  parameter int IMAGE_SIZE    = 8,
  parameter int KERNEL_SIZE   = 3,
  parameter int OUT_ROWS      = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int ROW_CNT_WIDTH = 3,
  parameter int TIMEOUT       = 64,
  parameter int TO_WIDTH      = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     i_start,
  input  logic [1:0]               i_ack,
  output logic [1:0]               o_cmd,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [ROW_CNT_WIDTH-1:0] o_row_count
);

  ctrl_state_e              r_state;
  ctrl_state_e              w_state_nxt;
  logic [1:0]               r_cmd;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [ROW_CNT_WIDTH-1:0] r_row_count;

  logic [1:0]               w_cmd_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic                     w_error_nxt;
  logic [ROW_CNT_WIDTH-1:0] w_row_nxt;
  logic [ROW_CNT_WIDTH-1:0] w_row_inc;

  logic w_ack_match;
  logic w_last_row;
  logic w_start_ok;
  logic w_expired;
  logic w_watch_clear;
  logic w_watch_run;

  assign w_ack_match   = is_wait(r_state) && (i_ack == expected_ack(r_state));
  assign w_row_inc     = r_row_count + 1'b1;
  assign w_last_row    = (w_row_inc == ROW_CNT_WIDTH'(OUT_ROWS));
  assign w_start_ok    = i_start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
  // A REQ state always hands over to its WAIT state, so clearing here means
  // every WAIT starts from zero.
  assign w_watch_clear = is_req(r_state);
  assign w_watch_run   = is_wait(r_state);

  conv_layer_ack_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .TO_WIDTH (TO_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (i_enable),
    .i_clear   (w_watch_clear),
    .i_run     (w_watch_run),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_row_count <= '0;
    end else if (i_enable) begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_row_count <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (i_start) w_state_nxt = ST_PRE_REQ;
      ST_PRE_REQ:   w_state_nxt = ST_PRE_WAIT;
      ST_SHIFT_REQ: w_state_nxt = ST_SHIFT_WAIT;
      ST_LOAD_REQ:  w_state_nxt = ST_LOAD_WAIT;
      ST_PRE_WAIT, ST_LOAD_WAIT: begin
        // A matching ack beats a simultaneous timeout.
        if (w_ack_match)    w_state_nxt = ST_SHIFT_REQ;
        else if (w_expired) w_state_nxt = ST_ERROR;
      end
      ST_SHIFT_WAIT: begin
        if (w_ack_match)    w_state_nxt = w_last_row ? ST_DONE : ST_LOAD_REQ;
        else if (w_expired) w_state_nxt = ST_ERROR;
      end
      ST_DONE:      w_state_nxt = ST_IDLE;
      ST_ERROR:     if (i_start) w_state_nxt = ST_PRE_REQ;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_nxt   = req_cmd(w_state_nxt);
    w_busy_nxt  = !(w_state_nxt inside {ST_IDLE, ST_DONE, ST_ERROR});
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_error_nxt = (w_state_nxt == ST_ERROR);
    w_row_nxt   = r_row_count;
    if (w_start_ok) begin
      w_row_nxt = '0;
    end else if ((r_state == ST_SHIFT_WAIT) && w_ack_match) begin
      w_row_nxt = w_row_inc;
    end
  end

  assign o_cmd       = r_cmd;
  assign o_busy      = r_busy;
  // done is suppressed while the layer is stalled; the DONE state itself is held.
  assign o_done      = r_done & i_enable;
  assign o_error     = r_error;
  assign o_row_count = r_row_count;

endmodule

// File: tb/tb_conv_layer_input_controller.sv
// Self-checking bench for conv_layer_input_controller: behavioural pass model
// plus directed scenarios with a scripted ack responder.
module tb_conv_layer_input_controller;
  import conv_layer_pkg::*;

  localparam int OUT_ROWS = 6;
  localparam int TIMEOUT  = 64;
  localparam int N_STEPS  = 2 * OUT_ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_ack = 2'd0;
  logic [1:0] o_cmd;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [2:0] o_row_count;

  always #5 clk = ~clk;

  conv_layer_input_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (i_enable),
    .i_start     (i_start),
    .i_ack       (i_ack),
    .o_cmd       (o_cmd),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_row_count (o_row_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pass model: a pass is the command list PRELOAD, then SHIFT/LOAD alternating,
  // 2*OUT_ROWS steps; each step is one issue cycle followed by a wait for its ack.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3, P_ERR = 4;
  int         m_phase = P_IDLE;
  int         m_step = 0;
  int         m_wait = 0;
  int         m_rows = 0;
  logic       m_busy = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_cmd = 2'd0;

  function automatic logic [1:0] step_code(input int k);
    if (k == 0) return 2'd1;
    return (k % 2 == 1) ? 2'd2 : 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_step = 0; m_wait = 0; m_rows = 0;
      m_busy = 1'b0; m_err = 1'b0; m_cmd = 2'd0;
    end else if (i_enable) begin
      case (m_phase)
        P_IDLE, P_ERR: if (i_start) begin
          m_phase = P_ISSUE; m_step = 0; m_rows = 0;
          m_busy = 1'b1; m_err = 1'b0; m_cmd = step_code(0);
        end
        P_DONE: m_phase = P_IDLE;
        P_ISSUE: begin m_phase = P_WAIT; m_wait = 0; m_cmd = 2'd0; end
        P_WAIT: begin
          if (i_ack == step_code(m_step)) begin
            if (m_step % 2 == 1) m_rows++;
            if (m_step == N_STEPS - 1) begin
              m_phase = P_DONE; m_busy = 1'b0;
            end else begin
              m_step++; m_phase = P_ISSUE; m_cmd = step_code(m_step);
            end
          end else if (m_wait + 1 == TIMEOUT) begin
            m_phase = P_ERR; m_busy = 1'b0; m_err = 1'b1;
          end else begin
            m_wait++;
          end
        end
        default: ;
      endcase
    end
  end

  bit         cmp_on = 1'b0;
  logic [1:0] prev_cmd = 2'd0;
  logic [1:0] pulses[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmd", o_cmd, m_cmd);
      chk("busy", o_busy, m_busy);
      chk("error", o_error, m_err);
      chk("row_count", o_row_count, m_rows);
      chk("done", o_done, (m_phase == P_DONE) && i_enable);
      if (o_cmd != 2'd0 && prev_cmd == 2'd0) pulses.push_back(o_cmd);
      if (o_done) done_cnt++;
      prev_cmd = o_cmd;
    end
  end

  // Ack responder: counts enabled cycles after each new command pulse.
  int         d_pre = 25, d_shift = 10, d_load = 8;
  bit         drop_pre = 1'b0;
  bit         inject_wrong = 1'b0;
  int         pend = 0, pend2 = 0;
  logic [1:0] pend_code = 2'd0;
  logic [1:0] rprev = 2'd0;
  int         wrong_chk = 0;
  logic [2:0] wrong_rows = 3'd0;

  task automatic cyc();
    @(posedge clk);
    #2;
    i_ack = ACK_IDLE;
    if (i_enable && pend > 0) begin
      pend--;
      if (pend == 0) i_ack = pend_code;
    end
    if (wrong_chk > 0) begin
      wrong_chk--;
      if (wrong_chk == 0) begin
        chk("wrong_ack_rows", o_row_count, wrong_rows);
        chk("wrong_ack_cmd", o_cmd, 0);
      end
    end
    if (i_enable && pend2 > 0) begin
      pend2--;
      if (pend2 == 0) begin
        i_ack = ACK_LOAD_FIN;
        wrong_rows = o_row_count;
        wrong_chk = 2;
      end
    end
    if (o_cmd != 2'd0 && rprev == 2'd0) begin
      case (o_cmd)
        2'd1: if (!drop_pre) begin pend = d_pre; pend_code = ACK_PRELOAD_FIN; end
        2'd2: begin
          pend = d_shift; pend_code = ACK_SHIFT_FIN;
          if (inject_wrong) begin pend2 = 4; inject_wrong = 1'b0; end
        end
        default: begin pend = d_load; pend_code = ACK_LOAD_FIN; end
      endcase
    end
    rprev = o_cmd;
  endtask

  task automatic start_pass(input string tag);
    pulses.delete();
    done_cnt = 0;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    chk({tag, "_start_cmd"}, o_cmd, 1);
    chk({tag, "_start_busy"}, o_busy, 1);
  endtask

  task automatic wait_cmd(input logic [1:0] code, input string tag);
    int n;
    n = 0;
    while (o_cmd !== code && n < 500) begin cyc(); n++; end
    chk({tag, "_reached"}, (o_cmd === code), 1);
  endtask

  task automatic run_to_done(input string tag, input int stray_a, input int stray_b);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      cyc();
      if (o_done === 1'b1) begin seen = 1'b1; break; end
      i_start = (n == stray_a) || (n == stray_b);
    end
    i_start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_final_rows"}, o_row_count, 6);
    chk({tag, "_busy_with_done"}, o_busy, 0);
    cyc();
    chk({tag, "_done_width"}, o_done, 0);
  endtask

  task automatic check_seq(input string tag);
    logic [1:0] exp_seq[12];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
    chk({tag, "_pulse_count"}, pulses.size(), 12);
    chk({tag, "_done_count"}, done_cnt, 1);
    for (int i = 0; i < 12 && i < pulses.size(); i++)
      chk({tag, "_pulse_code"}, pulses[i], exp_seq[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int held;
    logic [2:0] rows_before;

    #3 rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("rst_cmd", o_cmd, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_rows", o_row_count, 0);

    // Nominal pass with stray starts while busy
    start_pass("nom");
    run_to_done("nom", 30, 100);
    check_seq("nom");

    // Preload never acknowledged
    drop_pre = 1'b1;
    start_pass("to");
    cyc();
    n = 0;
    while (o_error !== 1'b1 && n < 200) begin cyc(); n++; end
    chk("to_cycles_in_wait", n, 64);
    chk("to_busy", o_busy, 0);
    chk("to_cmd", o_cmd, 0);
    repeat (3) cyc();
    chk("to_error_sticky", o_error, 1);
    drop_pre = 1'b0;
    start_pass("restart");
    chk("restart_error_cleared", o_error, 0);
    run_to_done("restart", -1, -1);
    check_seq("restart");

    // Ack on the same cycle the watchdog reaches TIMEOUT wins
    d_pre = 64;
    start_pass("edge64");
    run_to_done("edge64", -1, -1);
    check_seq("edge64");
    chk("edge64_no_error", o_error, 0);

    // One cycle later is too late
    d_pre = 65;
    start_pass("edge65");
    n = 0;
    while (o_error !== 1'b1 && n < 200) begin cyc(); n++; end
    chk("edge65_error", o_error, 1);
    repeat (3) cyc();
    chk("edge65_late_ack_ignored", o_cmd, 0);
    d_pre = 25;

    // Wrong ack during SHIFT_WAIT
    inject_wrong = 1'b1;
    start_pass("wrong");
    run_to_done("wrong", -1, -1);
    check_seq("wrong");

    // Long stall inside LOAD_WAIT
    start_pass("stall_ld");
    wait_cmd(2'd3, "stall_ld_load");
    repeat (3) cyc();
    rows_before = o_row_count;
    i_enable = 1'b0;
    repeat (100) cyc();
    chk("stall_ld_rows", o_row_count, rows_before);
    chk("stall_ld_rows_lit", rows_before, 1);
    chk("stall_ld_error", o_error, 0);
    chk("stall_ld_busy", o_busy, 1);
    i_enable = 1'b1;
    run_to_done("stall_ld", -1, -1);
    check_seq("stall_ld");

    // Stall while the SHIFT command is on the bus
    start_pass("stall_sh");
    wait_cmd(2'd2, "stall_sh_shift");
    i_enable = 1'b0;
    held = 0;
    repeat (5) begin
      cyc();
      if (o_cmd == 2'd2) held++;
    end
    chk("stall_sh_cmd_held", held, 5);
    i_enable = 1'b1;
    chk("stall_sh_cmd_one_more", o_cmd, 2);
    cyc();
    chk("stall_sh_cmd_drop", o_cmd, 0);
    run_to_done("stall_sh", -1, -1);
    check_seq("stall_sh");

    // Reset after the third SHIFT_FIN
    start_pass("rst_mid");
    n = 0;
    while (o_row_count !== 3'd3 && n < 500) begin cyc(); n++; end
    chk("rst_mid_reached_row3", o_row_count, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cmd", o_cmd, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_error", o_error, 0);
    chk("rst_mid_rows", o_row_count, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    pend = 0;
    pend2 = 0;
    cyc();
    start_pass("after_rst");
    run_to_done("after_rst", -1, -1);
    check_seq("after_rst");

    repeat (3) cyc();
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_input_controller.md
Name: conv_layer_input_controller

Overview:
- Upper-hierarchy sequencer that drives the cmd/ack handshake of the conv layer input interface for one full image pass.
- Issues one PRELOAD, then alternates SHIFT and LOAD commands until all output rows have been shifted through the kernel array.
- Watches every handshake with a timeout and reports done, error and progress to the layer top.

Parameters:
- IMAGE_SIZE, 8, image width/height in pixels.
- KERNEL_SIZE, 3, kernel edge length.
- OUT_ROWS, 6, output rows per pass (IMAGE_SIZE-KERNEL_SIZE+1).
- ROW_CNT_WIDTH, 3, width of row counter.
- TIMEOUT, 64, max cycles spent in a WAIT state before error.
- TO_WIDTH, 7, watchdog counter width (holds TIMEOUT).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  global advance; same signal that gates the input interface.
- start  input  1  single-cycle request to begin a pass.
- ack  input  2  from input interface: 0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN.
- cmd  output  2  to input interface: 0 IDLE, 1 PRELOAD_START, 2 SHIFT_START, 3 LOAD_START.
- busy  output  1  high from accepted start until DONE/ERROR.
- done  output  1  one-cycle pulse at pass completion.
- error  output  1  sticky handshake-timeout flag.
- row_count  output  ROW_CNT_WIDTH  SHIFT_FIN acks received this pass.

Behaviour:
- Reset (asynchronous): state IDLE; cmd=0; busy=0; done=0; error=0; row_count=0; watchdog=0.
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered.
- enable=0 freezes everything: state, row_count, watchdog, cmd (cmd holds its value), busy, error. done is forced 0 while enable=0.
- States: IDLE, PRE_REQ, PRE_WAIT, SHIFT_REQ, SHIFT_WAIT, LOAD_REQ, LOAD_WAIT, DONE, ERROR.
- IDLE:
  - start=1 -> PRE_REQ; busy<=1; row_count<=0; error<=0.
  - start in any other state is ignored.
- X_REQ states:
  - cmd equals the matching code for exactly one enabled cycle.
  - Always goes to X_WAIT on the next enabled edge.
  - cmd<=IDLE on entry to every non-REQ state.
- PRE_WAIT: ack==PRELOAD_FIN -> SHIFT_REQ.
- SHIFT_WAIT: ack==SHIFT_FIN -> row_count<=row_count+1, then:
  - if row_count+1==OUT_ROWS -> DONE;
  - else -> LOAD_REQ.
- LOAD_WAIT: ack==LOAD_FIN -> SHIFT_REQ.
- Ack handling:
  - Ack is sampled only in WAIT states.
  - A non-matching nonzero ack in a WAIT state is ignored (no transition, no error).
  - Ack during REQ, IDLE or DONE is ignored.
- Watchdog:
  - Cleared on entry to each WAIT state; increments each enabled cycle in WAIT.
  - Reaching TIMEOUT without the matching ack -> ERROR.
  - A matching ack on the same cycle the count reaches TIMEOUT wins; no error.
- DONE: done=1 for that one cycle; busy<=0; next state IDLE.
- ERROR: error=1, busy=0, cmd=IDLE. Held until start (-> PRE_REQ, error cleared) or reset.
- Command counts per pass: 1 PRELOAD, OUT_ROWS SHIFT, OUT_ROWS-1 LOAD; no LOAD after the final SHIFT.
- Reset mid-pass returns to IDLE immediately; a later start begins from PRELOAD.

Decomposition:
- Shared package conv_layer_pkg holds:
  - cmd codes CMD_IDLE/PRELOAD_START/SHIFT_START/LOAD_START;
  - ack codes ACK_IDLE/PRELOAD_FIN/SHIFT_FIN/LOAD_FIN;
  - controller state enum.
- The input interface imports the same codes.
- One sub-module: conv_layer_ack_watchdog. Inputs: clk, rst_n, enable, clear, run. Output: expired when count==TIMEOUT.

Test Plan:
- Nominal pass:
  - Stimulus: start, with a responder model acking PRELOAD_FIN 25 cycles after preload, SHIFT_FIN 10 cycles after each shift, LOAD_FIN 8 cycles after each load.
  - Required: cmd pulse sequence 1,2,3,2,3,2,3,2,3,2,3,2 (1 preload, 6 shifts, 5 loads), each pulse 1 cycle wide; row_count reaches 6; one done pulse; busy falls with done.
- Timeout:
  - Stimulus: responder never returns PRELOAD_FIN.
  - Required: error=1 exactly 64 cycles after entering PRE_WAIT; busy=0; cmd=0; a new start clears error and reissues cmd=1.
- Wrong ack:
  - Stimulus: ACK_LOAD_FIN injected during SHIFT_WAIT.
  - Required: no transition, row_count unchanged; a later SHIFT_FIN advances normally.
- Enable stall:
  - Stimulus: enable=0 for 100 cycles during LOAD_WAIT.
  - Required: no timeout; state/watchdog frozen; pass completes after enable returns.
  - Stimulus: enable=0 while in SHIFT_REQ.
  - Required: cmd=2 held until enable returns, then cmd=2 for one more cycle.
- Reset and stray start:
  - Stimulus: rst_n low after 3rd SHIFT_FIN.
  - Required: all outputs return to reset values.
  - Stimulus: start pulses while busy.
  - Required: ignored, sequence unchanged.
